// File: rtl/dti_tniu_req_flit_packer.sv
// dti_tniu_req_flit_packer
// Splits wide DTI request beats (AXI4-Stream) into fixed-width flits for the
// TNIU request flit interface. A single-beat buffer holds the current beat
// while a segment index walks its flits. Segments beyond the last non-empty
// keep slice are skipped. The downstream threshold hint only delays the start
// of a new message; it never stalls a message that has already begun.

module dti_tniu_req_flit_packer #(
    parameter int IN_DATA_WIDTH   = 160,
    parameter int FLIT_DATA_WIDTH = 80,
    parameter int FLIT_KEEP_WIDTH = 10,
    parameter int TBU_NUM_WIDTH   = 6
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       s_tvalid,
    output logic                                       s_tready,
    input  logic [IN_DATA_WIDTH-1:0]                   s_tdata,
    input  logic [IN_DATA_WIDTH/8-1:0]                 s_tkeep,
    input  logic                                       s_tlast,
    input  logic [TBU_NUM_WIDTH-1:0]                   s_tid,
    input  logic [TBU_NUM_WIDTH-1:0]                   cfg_srcid,
    output logic                                       req_valid,
    output logic [FLIT_DATA_WIDTH+FLIT_KEEP_WIDTH-1:0] req_payload,
    output logic                                       req_last,
    output logic [TBU_NUM_WIDTH-1:0]                   req_srcid,
    output logic [TBU_NUM_WIDTH-1:0]                   req_tgtid,
    output logic                                       req_qos,
    input  logic                                       req_threshold,
    input  logic                                       req_ready,
    output logic                                       err_tid_mismatch
);

    localparam int SEG_NUM       = IN_DATA_WIDTH / FLIT_DATA_WIDTH;
    localparam int SEG_W         = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
    localparam int IN_KEEP_WIDTH = IN_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    // Registered state
    state_e                     r_state;
    logic                       r_buf_vld;
    logic [IN_DATA_WIDTH-1:0]   r_buf_data;
    logic [IN_KEEP_WIDTH-1:0]   r_buf_keep;
    logic                       r_buf_last;
    logic [SEG_W-1:0]           r_seg_idx;
    logic [TBU_NUM_WIDTH-1:0]   r_tgtid;
    logic                       r_err;

    // Combinational nets
    state_e                     w_state_nxt;
    logic [SEG_W-1:0]           w_final_seg;
    logic [FLIT_DATA_WIDTH-1:0] w_seg_data;
    logic [FLIT_KEEP_WIDTH-1:0] w_seg_keep;
    logic                       w_flit_fire;
    logic                       w_last_seg;
    logic                       w_beat_done;
    logic                       w_gate_ok;
    logic                       w_s_tready;
    logic                       w_accept;
    logic                       w_tid_mismatch;

    // Highest segment with any keep bit set; an all-zero keep still sends seg 0
    always_comb begin
        w_final_seg = {SEG_W{1'b0}};
        for (int i = 0; i < SEG_NUM; i++) begin
            if (r_buf_keep[i*FLIT_KEEP_WIDTH +: FLIT_KEEP_WIDTH] != {FLIT_KEEP_WIDTH{1'b0}}) begin
                w_final_seg = SEG_W'(i);
            end else begin
                w_final_seg = w_final_seg;
            end
        end
    end

    // Select the data/keep slice of the segment currently being presented
    always_comb begin
        w_seg_data = {FLIT_DATA_WIDTH{1'b0}};
        w_seg_keep = {FLIT_KEEP_WIDTH{1'b0}};
        for (int i = 0; i < SEG_NUM; i++) begin
            if (r_seg_idx == SEG_W'(i)) begin
                w_seg_data = r_buf_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
                w_seg_keep = r_buf_keep[i*FLIT_KEEP_WIDTH +: FLIT_KEEP_WIDTH];
            end else begin
                w_seg_data = w_seg_data;
                w_seg_keep = w_seg_keep;
            end
        end
    end

    // Handshake terms. Ready is combinational from the drain of the last
    // segment so a new beat can be loaded on the same edge (no bubble).
    // rst_n is folded in so upstream sees not-ready while reset is held.
    assign w_flit_fire    = r_buf_vld & req_ready;
    assign w_last_seg     = (r_seg_idx == w_final_seg);
    assign w_beat_done    = w_flit_fire & w_last_seg;
    assign w_gate_ok      = (r_state == ST_BODY) | ~req_threshold;
    assign w_s_tready     = (~r_buf_vld | w_beat_done) & w_gate_ok & rst_n;
    assign w_accept       = s_tvalid & w_s_tready;
    assign w_tid_mismatch = w_accept & (r_state == ST_BODY) & (s_tid != r_tgtid);

    // Message-boundary tracker: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !s_tlast) begin
                    w_state_nxt = ST_BODY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (w_accept && s_tlast) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BODY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Message-boundary tracker: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat buffer and segment walker; a reload takes priority over draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_vld  <= 1'b0;
            r_buf_data <= {IN_DATA_WIDTH{1'b0}};
            r_buf_keep <= {IN_KEEP_WIDTH{1'b0}};
            r_buf_last <= 1'b0;
            r_seg_idx  <= {SEG_W{1'b0}};
        end else if (w_accept) begin
            r_buf_vld  <= 1'b1;
            r_buf_data <= s_tdata;
            r_buf_keep <= s_tkeep;
            r_buf_last <= s_tlast;
            r_seg_idx  <= {SEG_W{1'b0}};
        end else if (w_beat_done) begin
            r_buf_vld  <= 1'b0;
            r_seg_idx  <= {SEG_W{1'b0}};
        end else if (w_flit_fire) begin
            r_seg_idx  <= r_seg_idx + SEG_W'(1);
        end else begin
            r_buf_vld  <= r_buf_vld;
            r_seg_idx  <= r_seg_idx;
        end
    end

    // Target id is captured on the first beat only; later beats cannot change it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgtid <= {TBU_NUM_WIDTH{1'b0}};
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_tgtid <= s_tid;
        end else begin
            r_tgtid <= r_tgtid;
        end
    end

    // One-cycle error pulse when a continuation beat carries a different tid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_tid_mismatch;
        end
    end

    // Flit interface mapping
    assign s_tready         = w_s_tready;
    assign req_valid        = r_buf_vld;
    assign req_payload      = {w_seg_keep, w_seg_data};
    assign req_last         = r_buf_last & w_last_seg;
    assign req_srcid        = cfg_srcid;
    assign req_tgtid        = r_tgtid;
    assign req_qos          = 1'b1;
    assign err_tid_mismatch = r_err;

endmodule

// File: doc/dti_tniu_req_flit_packer.md
Name: dti_tniu_req_flit_packer

Overview:
Request-side segmenter placed directly upstream of the TNIU top-side async-FIFO stage. It takes DTI request messages as a wide AXI4-Stream, splits each beat into fixed-width flits, and drives the req_* flit interface (payload, last, srcid, tgtid, qos) with valid/ready flow control. It honours the downstream req_threshold backpressure hint, but only at message boundaries.

Parameters:
IN_DATA_WIDTH, 160, width of the upstream AXI4-Stream tdata; must be an integer multiple of FLIT_DATA_WIDTH.
FLIT_DATA_WIDTH, 80, data bits per flit (CUSTOM_DATA_WIDTH).
FLIT_KEEP_WIDTH, 10, byte-keep bits per flit, equal to FLIT_DATA_WIDTH/8 (CUSTOM_KEEP_WIDTH).
TBU_NUM_WIDTH, 6, width of srcid/tgtid.
SEG_NUM (derived), IN_DATA_WIDTH/FLIT_DATA_WIDTH, number of flits per input beat (default 2).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_tvalid  in  1  upstream beat valid
s_tready  out  1  upstream beat ready
s_tdata  in  IN_DATA_WIDTH  beat data; segment 0 = LSBs
s_tkeep  in  IN_DATA_WIDTH/8  byte keep
s_tlast  in  1  last beat of message
s_tid  in  TBU_NUM_WIDTH  message target id
cfg_srcid  in  TBU_NUM_WIDTH  static source id of this TNIU
req_valid  out  1  flit valid
req_payload  out  FLIT_DATA_WIDTH+FLIT_KEEP_WIDTH  {keep_seg, data_seg}
req_last  out  1  last flit of message
req_srcid  out  TBU_NUM_WIDTH  = cfg_srcid
req_tgtid  out  TBU_NUM_WIDTH  target id latched at message start
req_qos  out  1  tied 1
req_threshold  in  1  downstream occupancy above threshold
req_ready  in  1  downstream accept
err_tid_mismatch  out  1  one-cycle pulse on a mid-message tid change

Behaviour:
- Reset: async on rst_n low. buf_vld=0, seg_idx=0, state=IDLE, tgtid_q=0, err_tid_mismatch=0. Resulting outputs: req_valid=0, req_last=0, s_tready=0 while rst_n is low. req_qos=1 always.
- Storage: a single-beat buffer (data, keep, last) plus seg_idx (clog2(SEG_NUM) bits).
- FSM states:
  - IDLE: at a message boundary.
  - BODY: message in progress.
  - Transitions: IDLE->BODY on accepting a beat with tlast=0. BODY->IDLE on accepting a beat with tlast=1. A single-beat message (tlast=1 in IDLE) stays in IDLE.
- flit_fire = req_valid & req_ready.
- final_seg = highest segment index whose keep slice is nonzero. If the whole keep is zero, final_seg = 0.
- beat_done = flit_fire & (seg_idx == final_seg).
- gate_ok = (state==BODY) | ~req_threshold.
  - Threshold only blocks the start of a new message. Assertion mid-message never stalls that message.
- s_tready = (~buf_vld | beat_done) & gate_ok.
  - Combinational. Gives zero-bubble back-to-back beats: 1 flit/cycle sustained.
- Beat accept (s_tvalid & s_tready): load the buffer, set buf_vld=1, seg_idx=0.
  - In IDLE, also latch tgtid_q=s_tid.
  - In BODY, if s_tid != tgtid_q: pulse err_tid_mismatch for 1 cycle and keep tgtid_q unchanged.
- beat_done without a new accept: buf_vld=0. flit_fire without beat_done: seg_idx+1.
- Output mapping (combinational from the buffer):
  - req_valid = buf_vld.
  - req_payload = {keep[seg_idx], data[seg_idx]}.
  - req_last = buf_last & (seg_idx==final_seg).
  - req_tgtid = tgtid_q; req_srcid = cfg_srcid.
- Latency: beat accepted at edge N -> flit 0 visible from cycle N+1.
- Output stability: once req_valid=1, payload/last/ids stay stable until flit_fire.
- Segments above final_seg are never sent. An all-zero-keep beat still sends one flit (seg 0, keep 0).
- Simultaneous beat_done and new accept: the buffer reloads in the same cycle and req_valid stays 1.
- seg_idx never exceeds SEG_NUM-1.

Test Plan:
- Reset mid-message (buffer full, seg_idx=1), rst_n low 1 cycle -> req_valid=0, state IDLE. The next beat's flits start at seg 0 carrying the new s_tid.
- One beat, tdata={80'hB..,80'hA..}, tkeep=all ones, tlast=1, tid=5, cfg_srcid=3, req_ready=1 -> 2 flits on consecutive cycles: payload {10'h3FF,A} last=0, then {10'h3FF,B} last=1. tgtid=5, srcid=3, qos=1.
- Beat with tkeep[19:10]=0, tlast=1 -> exactly 1 flit (seg 0) with last=1. Seg 1 is suppressed.
- Three-beat message, req_ready toggling 1/0 each cycle -> 6 flits, payload stable while stalled, last only on the 6th. s_tready is never high while the buffer is held.
- req_threshold=1 in IDLE -> s_tready=0 and no flits. Threshold asserting during beat 2 of a 3-beat message -> all 3 beats still accepted; the next message is held until threshold=0.
- Second beat of a message arrives with tid=7 after first-beat tid=5 -> err_tid_mismatch pulses for 1 cycle and all flits carry tgtid=5.
